// File: rtl/fpadd_pkg.sv
// Shared types and constants for the fpadd round-robin scheduler.
package fpadd_pkg;
  localparam int FP_W = 32;
  localparam logic [FP_W-1:0] FP_QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
endpackage

// File: rtl/fpadd_rr_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after rr_ptr, wrapping modulo N_REQ.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  rr_ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_idx,
  output logic             any_req
);
  int idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_req   = 1'b0;
    idx       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (!any_req && req[idx]) begin
        any_req       = 1'b1;
        grant_idx     = ID_W'(idx);
        grant[idx]    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fpadd_rr_sched.sv
// Shares one single-precision adder among N_REQ requesters; results return tagged with
// the requester ID, and a watchdog turns a missing adder done into a qNaN error response.
module fpadd_rr_sched
  import fpadd_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [FP_W*N_REQ-1:0] req_a,
  input  logic [FP_W*N_REQ-1:0] req_b,
  output logic [N_REQ-1:0]      req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [FP_W-1:0]       rsp_sum,
  output logic                  rsp_err,
  output logic                  fa_start,
  output logic [FP_W-1:0]       fa_a,
  output logic [FP_W-1:0]       fa_b,
  input  logic [FP_W-1:0]       fa_sum,
  input  logic                  fa_done,
  output logic                  busy,
  output state_t                dbg_state
);
  // Handshakes: a transfer happens on any rising edge where valid & ready are both high.
  // req_ready is combinational and only asserted in IDLE; rsp_valid holds until rsp_ready.
  state_t          state, state_nxt;
  logic [ID_W-1:0] rr_ptr, id_q, gnt_idx;
  logic [N_REQ-1:0] gnt;
  logic            any_req;
  logic [7:0]      wd;
  logic            wd_expired;

  rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (gnt),
    .grant_idx (gnt_idx),
    .any_req   (any_req)
  );

  assign wd_expired = (wd == 8'(TIMEOUT - 1));
  assign busy       = (state != IDLE);
  assign dbg_state  = state;

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    fa_start  = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: if (any_req) begin
        req_ready = gnt;
        state_nxt = ISSUE;
      end
      ISSUE: begin
        fa_start  = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: if (fa_done || wd_expired) state_nxt = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // A grant during reset would be lost, so never signal acceptance then.
    if (reset) req_ready = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      id_q    <= '0;
      wd      <= '0;
      fa_a    <= '0;
      fa_b    <= '0;
      rsp_id  <= '0;
      rsp_sum <= '0;
      rsp_err <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (any_req) begin
          fa_a   <= req_a[gnt_idx*FP_W +: FP_W];
          fa_b   <= req_b[gnt_idx*FP_W +: FP_W];
          id_q   <= gnt_idx;
          rr_ptr <= (int'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + 1'b1;
        end
        ISSUE: wd <= '0;
        WAIT: begin
          // A done arriving in the timeout cycle still wins over the abort.
          if (fa_done) begin
            rsp_sum <= fa_sum;
            rsp_id  <= id_q;
            rsp_err <= 1'b0;
          end else if (wd_expired) begin
            rsp_sum <= FP_QNAN;
            rsp_id  <= id_q;
            rsp_err <= 1'b1;
          end else begin
            wd <= wd + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fpadd_rr_sched.sv
// Bench for fpadd_rr_sched: transaction-level reference model (grant picks, response
// queue, expected response cycle) plus a behavioural adder with configurable latency.
module tb_fpadd_rr_sched;
  import fpadd_pkg::*;
  localparam int N   = 4;
  localparam int IW  = 2;
  localparam int TO  = 64;
  localparam int RW  = 1 + IW + FP_W;
  localparam int BIG = 32'h3fff_ffff;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req_valid, req_ready;
  logic [FP_W*N-1:0] req_a, req_b;
  logic            rsp_valid, rsp_ready, rsp_err, fa_start, fa_done, busy;
  logic [IW-1:0]   rsp_id;
  logic [FP_W-1:0] rsp_sum, fa_a, fa_b, fa_sum;
  state_t          dbg_state;

  fpadd_rr_sched #(.N_REQ(N), .ID_W(IW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_sum(rsp_sum), .rsp_err(rsp_err), .fa_start(fa_start), .fa_a(fa_a), .fa_b(fa_b),
    .fa_sum(fa_sum), .fa_done(fa_done), .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // requesters and behavioural adder
  logic [N-1:0]    rv;
  logic [FP_W-1:0] ra[N], rb[N];
  int              cyc;
  bit              pend;
  int              done_at;
  logic [FP_W-1:0] pend_sum, fix_sum;
  bit              rand_lat, adder_never, fix_en, stray_en, rand_req, rand_rdy, hold_all;
  int              adder_lat;

  // reference model / scoreboard
  bit              m_busy;
  int              m_ptr, m_id, grant_cyc, resp_at, start_cyc, rsp_rise_cyc;
  logic [FP_W-1:0] m_a, m_b;
  logic [RW-1:0]   exp_q[$];
  int              glog[$];
  bit              last_valid, prev_rsp_valid;

  task automatic m_reset();
    m_busy    = 0;
    m_ptr     = 0;
    grant_cyc = -10;
    resp_at   = BIG;
    exp_q.delete();
  endtask

  task automatic tick();
    int g, r, lat;
    bit never, exp_start, exp_valid;
    logic [N-1:0] exp_rdy;
    // drive phase
    for (int i = 0; i < N; i++) begin
      if (hold_all && !rv[i]) begin
        rv[i] = 1'b1; ra[i] = $urandom; rb[i] = $urandom;
      end else if (rand_req && !rv[i]) begin
        if ($urandom_range(0, 3) == 0) begin
          rv[i] = 1'b1; ra[i] = $urandom; rb[i] = $urandom;
        end
      end else if (rand_req && $urandom_range(0, 15) == 0) begin
        rv[i] = 1'b0;
      end
    end
    if (rand_rdy) rsp_ready = ($urandom_range(0, 9) < 7);
    req_valid = rv;
    for (int i = 0; i < N; i++) begin
      req_a[i*FP_W +: FP_W] = ra[i];
      req_b[i*FP_W +: FP_W] = rb[i];
    end
    fa_done = 1'b0;
    fa_sum  = $urandom;
    if (pend && cyc == done_at) begin
      fa_done = 1'b1; fa_sum = pend_sum; pend = 0;
    end else if (stray_en && !pend && (!m_busy || cyc == grant_cyc + 1 || cyc >= resp_at)
                 && $urandom_range(0, 7) == 0) begin
      fa_done = 1'b1;
    end
    #1;
    // sample / check phase
    chk("busy", busy, m_busy);
    exp_rdy   = '0;
    exp_start = m_busy && (cyc == grant_cyc + 1);
    if (m_busy && cyc > grant_cyc) begin
      chk("fa_a", fa_a, m_a);
      chk("fa_b", fa_b, m_b);
    end
    if (!m_busy && rv != '0) begin
      g = -1;
      for (int k = 0; k < N; k++) if (g < 0 && rv[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      exp_rdy[g] = 1'b1;
      m_busy = 1; m_id = g; m_a = ra[g]; m_b = rb[g]; grant_cyc = cyc;
      m_ptr = (g + 1) % N;
      glog.push_back(g);
      rv[g] = 1'b0;
    end
    chk("req_ready", req_ready, exp_rdy);
    chk("fa_start", fa_start, exp_start);
    if (exp_start) begin
      start_cyc = cyc;
      if (rand_lat) begin
        r     = $urandom_range(0, 99);
        never = (r < 3);
        lat   = (r < 10) ? $urandom_range(62, 66) : $urandom_range(1, 8);
      end else begin
        never = adder_never;
        lat   = adder_lat;
      end
      pend_sum = fix_en ? fix_sum : $urandom;
      pend     = !never;
      done_at  = cyc + lat;
      if (!never && lat <= TO) begin
        resp_at = cyc + lat + 1;
        exp_q.push_back({1'b0, IW'(m_id), pend_sum});
      end else begin
        resp_at = cyc + TO + 1;
        exp_q.push_back({1'b1, IW'(m_id), FP_QNAN});
      end
    end
    exp_valid  = m_busy && cyc >= resp_at;
    last_valid = exp_valid;
    if (rsp_valid && !prev_rsp_valid) rsp_rise_cyc = cyc;
    prev_rsp_valid = rsp_valid;
    chk("rsp_valid", rsp_valid, exp_valid);
    if (exp_valid && exp_q.size() > 0) begin
      chk("rsp_tuple", {rsp_err, rsp_id, rsp_sum}, exp_q[0]);
      if (rsp_ready) begin
        void'(exp_q.pop_front());
        m_busy  = 0;
        resp_at = BIG;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_grants(input int n, input int budget);
    int target, b;
    target = glog.size() + n;
    b = 0;
    while (glog.size() < target && b < budget) begin tick(); b++; end
    chk("grant_budget", glog.size(), target);
  endtask

  task automatic run_idle(input int budget);
    int b;
    b = 0;
    while (m_busy && b < budget) begin tick(); b++; end
    chk("idle_budget", m_busy, 0);
  endtask

  task automatic chk_reset_out();
    chk("rst_state", dbg_state, IDLE);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_sum", rsp_sum, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_fa_start", fa_start, 0);
    chk("rst_fa_a", fa_a, 0);
    chk("rst_fa_b", fa_b, 0);
    chk("rst_busy", busy, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1; rv = '0; req_valid = '0; fa_done = 1'b0; pend = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    m_reset();
    chk_reset_out();
    reset = 1'b0;
  endtask

  int base;
  int rr_exp[6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    rv = '0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    fa_done = 1'b0; fa_sum = '0; cyc = 0; pend = 0; prev_rsp_valid = 0;
    rand_lat = 0; adder_never = 0; fix_en = 0; stray_en = 0; rand_req = 0; rand_rdy = 0;
    hold_all = 0; adder_lat = 3; fix_sum = '0; rsp_rise_cyc = 0; start_cyc = 0;
    for (int i = 0; i < N; i++) begin ra[i] = '0; rb[i] = '0; end
    m_reset();
    do_reset();

    // single request, adder done 3 cycles after start
    rv = 4'b0001; ra[0] = 32'h3F80_0000; rb[0] = 32'h4000_0000;
    fix_en = 1; fix_sum = 32'h4040_0000; adder_lat = 3;
    base = glog.size();
    tick();
    chk("single_first_cycle_grant", glog.size(), base + 1);
    run_idle(20);
    fix_en = 0;

    // round-robin with everyone continuously valid
    do_reset();
    hold_all = 1; adder_lat = 2; rsp_ready = 1'b1;
    base = glog.size();
    run_grants(6, 100);
    hold_all = 0;
    for (int k = 0; k < 6; k++) chk("rr_order", glog[base + k], rr_exp[k]);

    // pointer skip: last grant was 1, only 0 and 3 remain valid
    rv = 4'b1001;
    base = glog.size();
    run_grants(2, 100);
    chk("skip_first", glog[base], 3);
    chk("skip_second", glog[base + 1], 0);

    // back-pressure for 10 response cycles with requester 2 waiting
    rsp_ready = 1'b0;
    rv[2] = 1'b1; ra[2] = $urandom; rb[2] = $urandom;
    base = 0;
    while (!last_valid && base < 100) begin tick(); base++; end
    chk("bp_resp_seen", last_valid, 1);
    repeat (9) tick();
    rsp_ready = 1'b1;
    tick();
    base = glog.size();
    tick();
    chk("bp_grant_cnt", glog.size(), base + 1);
    chk("bp_grant_id", glog[glog.size() - 1], 2);
    run_idle(20);

    // timeout: adder never answers
    adder_never = 1;
    rv[3] = 1'b1; ra[3] = $urandom; rb[3] = $urandom;
    run_grants(1, 10);
    run_idle(100);
    chk("timeout_latency", rsp_rise_cyc - start_cyc, TO + 1);
    adder_never = 0;

    // done exactly in the timeout cycle wins
    adder_lat = TO;
    rv[1] = 1'b1; ra[1] = $urandom; rb[1] = $urandom;
    run_grants(1, 10);
    run_idle(100);
    chk("edge_latency", rsp_rise_cyc - start_cyc, TO + 1);

    // reset two cycles after fa_start, adder done lands afterwards
    adder_lat = 5;
    rv[2] = 1'b1; ra[2] = $urandom; rb[2] = $urandom;
    run_grants(1, 10);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; rv = '0; req_valid = '0;
    m_reset();
    #1;
    chk_reset_out();
    repeat (6) tick();
    rv = 4'b1111;
    for (int i = 0; i < N; i++) begin ra[i] = $urandom; rb[i] = $urandom; end
    base = glog.size();
    tick();
    chk("post_reset_grant", glog[glog.size() - 1], 0);
    chk("post_reset_cnt", glog.size(), base + 1);
    adder_lat = 2;
    run_idle(20);

    // randomized traffic, latencies, back-pressure and stray done pulses
    rand_req = 1; rand_rdy = 1; rand_lat = 1; stray_en = 1;
    repeat (6000) tick();
    rand_req = 0; rand_rdy = 0; rand_lat = 0; stray_en = 0;
    rsp_ready = 1'b1; rv = '0;
    run_idle(200);
    chk("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
